mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, number of extra bus cycles per access (0..15).
REQ-002 SHALL have ports (clock and reset first; one clock; reset is synchronous and active-high):
- clk  in  1  clock
- clr  in  1  synchronous active-high reset
- req_i  in  1  load/store request from the pipeline
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- paddr_i  in  32  physical address from the translation stage
- mmu_error_i  in  1  translation fault from the translation stage
- wdata_i  in  32  store data, right-aligned
- rdata_o  out  32  load data, zero-extended
- stall_o  out  1  pipeline stall request
- fault_o  out  1  access fault, same cycle as the request
- bus_cs_o  out  1  bus chip select
- bus_we_o  out  1  bus write enable
- bus_addr_o  out  32  word address, bits [1:0] = 0
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  lane-replicated write data
- bus_rdata_i  in  32  bus read data

Function
REQ-003 SHALL implement an FSM with states IDLE, ACCESS and DONE.
REQ-004 In IDLE, a request (req_i high, no fault) SHALL latch the address, we, byte enables and wdata, load the wait counter with WAIT_CYCLES, and move to ACCESS.
REQ-005 In IDLE, req_i with mmu_error_i high SHALL drive fault_o high combinationally and keep stall_o low; no bus cycle starts and the state stays IDLE.
REQ-006 stall_o SHALL be high in the accepting IDLE cycle and in every ACCESS cycle; it SHALL be low in DONE and in idle IDLE.
REQ-007 In ACCESS, bus_cs_o SHALL be high; bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o SHALL be driven from registers and held stable; the counter SHALL decrement each cycle.
REQ-008 When the counter is 0 in ACCESS, the block SHALL capture bus_rdata_i (for loads) and move to DONE.
REQ-009 ACCESS SHALL last WAIT_CYCLES+1 cycles, so a request in cycle 0 completes in DONE at cycle WAIT_CYCLES+2.
REQ-010 In DONE, rdata_o SHALL hold the selected lane zero-extended (byte lane paddr[1:0]; half lane paddr[1]; word whole).
REQ-011 DONE SHALL ignore req_i and return to IDLE after exactly one cycle.
REQ-012 rdata_o SHALL hold its value until the next load completes; stores SHALL NOT change rdata_o.
REQ-013 Byte enables SHALL be:
- byte: 0001 shifted left by paddr[1:0]
- half: 0011 if paddr[1]=0, else 1100
- word: 1111
REQ-014 bus_wdata_o SHALL be formed as follows: byte replicated x4; half replicated x2; word as-is.
REQ-015 Outside ACCESS, bus_cs_o, bus_we_o and bus_be_o SHALL be 0.

Reset
REQ-016 With clr high at a clock edge, the next state SHALL be IDLE, and:
- stall_o, bus_cs_o, bus_we_o and bus_be_o SHALL be 0
- bus_addr_o, bus_wdata_o and rdata_o SHALL be 0
- the counter SHALL be 0
REQ-017 clr during ACCESS SHALL abort the transfer without a completion cycle; clr SHALL have priority over every request.

Configuration
REQ-018 The macro MEM_ALIGN_CHECK_EN SHALL select alignment handling as follows:
- defined: a half access with paddr[0]=1, or a word access with paddr[1:0]!=0, SHALL raise fault_o exactly like mmu_error_i
- undefined: misaligned low address bits SHALL be ignored (half uses paddr[1] only, word ignores [1:0]) and fault_o SHALL depend only on mmu_error_i

Structure
REQ-019 A shared package mem_pkg SHALL hold the size encodings, the FSM state enum, the byte-enable constants and the counter width.
REQ-020 A combinational sub-module mem_lane SHALL generate byte enables, replicate write data and extract read lanes; mem_bus_ctrl instantiates it once.

Verification
REQ-021 Word load, WAIT_CYCLES=2, paddr=0x0000_1004, bus_rdata=0xDEADBEEF -> bus_cs high for cycles 1-3; stall_o high for cycles 0-3; cycle 4 is DONE with rdata_o=0xDEADBEEF and bus_addr_o=0x0000_1004.
REQ-022 Byte store, paddr=0x0000_2003, wdata=0x0000_00A5 -> bus_be_o=1000, bus_wdata_o=0xA5A5A5A5, bus_we_o=1, bus_addr_o=0x0000_2000.
REQ-023 Request with mmu_error_i=1 -> fault_o=1 the same cycle, stall_o=0, bus_cs_o stays 0, state stays IDLE.
REQ-024 Half load at paddr=0x0000_3001: with MEM_ALIGN_CHECK_EN -> fault_o=1 and no bus cycle; without it -> bus_be_o=0011 and rdata_o=0x0000_BEEF from bus 0xDEADBEEF.
REQ-025 clr asserted in the second ACCESS cycle -> the next cycle has bus_cs_o=0, stall_o=0, rdata_o=0, and a new request is accepted normally.
REQ-026 WAIT_CYCLES=0, back-to-back requests held high -> ACCESS for 1 cycle, DONE, IDLE, and the next request is accepted only in IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg: shared definitions for the memory bus controller.
//   - access size encodings (size_i)
//   - controller FSM state enum
//   - byte-enable constants
//   - wait counter width
//   - misalignment helper, used when MEM_ALIGN_CHECK_EN is defined
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // A half access must sit on an even address; a word access on a
    // multiple of four. Bytes are never misaligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            default:   bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane.sv
// -----------------------------------------------------------------------------
// mem_lane: combinational lane steering for the memory bus controller.
// Ports:
//   i_size  [1:0]  access size (00 byte, 01 half, 10/11 word)
//   i_off   [1:0]  low address bits of the access
//   i_wdata [31:0] right-aligned store data
//   i_rdata [31:0] raw bus read data
//   o_be    [3:0]  byte enables
//   o_wdata [31:0] lane-replicated store data
//   o_rdata [31:0] selected read lane, zero-extended
// Half accesses look at i_off[1] only; word accesses ignore i_off.
// -----------------------------------------------------------------------------
module mem_lane
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    // Byte enables, write replication and read lane extraction by size.
    always_comb begin
        o_be    = BE_NONE;
        o_wdata = 32'h0000_0000;
        o_rdata = 32'h0000_0000;
        case (i_size)
            SIZE_BYTE: begin
                o_be    = BE_BYTE << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {24'h00_0000, i_rdata[{i_off, 3'b000} +: 8]};
            end
            SIZE_HALF: begin
                if (i_off[1]) begin
                    o_be    = BE_HALF_HI;
                    o_rdata = {16'h0000, i_rdata[31:16]};
                end else begin
                    o_be    = BE_HALF_LO;
                    o_rdata = {16'h0000, i_rdata[15:0]};
                end
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = BE_WORD;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl: load/store unit bus controller (IDLE -> ACCESS -> DONE).
// Parameter WAIT_CYCLES (0..15): extra bus cycles per access; ACCESS lasts
// WAIT_CYCLES+1 cycles, then one DONE cycle.
// Ports:
//   clk, clr           clock, synchronous active-high reset
//   req_i, we_i        request, 1 = store
//   size_i [1:0]       00 byte, 01 half, 10/11 word
//   paddr_i [31:0]     physical address
//   mmu_error_i        translation fault
//   wdata_i [31:0]     right-aligned store data
//   rdata_o [31:0]     zero-extended load data, held until the next load
//   stall_o            pipeline stall (accepting IDLE cycle and ACCESS)
//   fault_o            access fault, combinational in the request cycle
//   bus_cs_o/we_o/addr_o/be_o/wdata_o, bus_rdata_i   memory bus
// Configuration macro: MEM_ALIGN_CHECK_EN -- when defined, misaligned half
// and word accesses fault like mmu_error_i; otherwise low bits are ignored.
// -----------------------------------------------------------------------------
module mem_bus_ctrl
    import mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
)
(
    input  logic        clk,
    input  logic        clr,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] paddr_i,
    input  logic        mmu_error_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        fault_o,
    output logic        bus_cs_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i
);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_addr;
    logic               r_we;
    logic [1:0]         r_size;
    logic [1:0]         r_off;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;

    state_e             w_next;
    logic               w_accept;
    logic               w_stall;
    logic               w_fault;
    logic               w_bad;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata_rep;
    logic [31:0]        w_rdata_sel;

    // Lane logic works on the latched access, so bus outputs stay stable
    // through ACCESS regardless of what the pipeline does meanwhile.
    mem_lane u_lane (
        .i_size  (r_size),
        .i_off   (r_off),
        .i_wdata (r_wdata),
        .i_rdata (bus_rdata_i),
        .o_be    (w_be),
        .o_wdata (w_wdata_rep),
        .o_rdata (w_rdata_sel)
    );

    // Fault qualification of an incoming request.
    always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
        w_bad = mmu_error_i | is_misaligned(size_i, paddr_i[1:0]);
`else
        w_bad = mmu_error_i;
`endif
    end

    // Next-state, accept, stall and fault decode.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_stall  = 1'b0;
        w_fault  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    if (w_bad) begin
                        w_fault = 1'b1;
                        w_next  = IDLE;
                    end else begin
                        w_accept = 1'b1;
                        w_stall  = 1'b1;
                        w_next   = ACCESS;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            ACCESS: begin
                w_stall = 1'b1;
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_next = DONE;
                end else begin
                    w_next = ACCESS;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, counter, latched access and load data registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_addr  <= 32'h0000_0000;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_off   <= 2'b00;
            r_wdata <= 32'h0000_0000;
            r_rdata <= 32'h0000_0000;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= {paddr_i[31:2], 2'b00};
                r_we    <= we_i;
                r_size  <= size_i;
                r_off   <= paddr_i[1:0];
                r_wdata <= wdata_i;
                r_cnt   <= CNT_W'(WAIT_CYCLES);
            end else if (r_state == ACCESS) begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    // Last bus cycle: sample read data; stores leave it alone.
                    if (!r_we) begin
                        r_rdata <= w_rdata_sel;
                    end
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

    assign stall_o     = w_stall;
    assign fault_o     = w_fault;
    assign bus_cs_o    = (r_state == ACCESS);
    assign bus_we_o    = (r_state == ACCESS) & r_we;
    assign bus_be_o    = (r_state == ACCESS) ? w_be : BE_NONE;
    assign bus_addr_o  = r_addr;
    assign bus_wdata_o = w_wdata_rep;
    assign rdata_o     = r_rdata;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_ctrl: directed, table-driven bench for mem_bus_ctrl.
// Main instance uses WAIT_CYCLES=2; a second instance with WAIT_CYCLES=0
// covers back-to-back requests.
// -----------------------------------------------------------------------------
module tb_mem_bus_ctrl;

    localparam int WAIT = 2;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [31:0] paddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mmu;
        logic        exp_fault;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        req, we, mmu;
    logic [1:0]  size;
    logic [31:0] paddr, wdata, bus_rdata;
    logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
    logic        stall_o, fault_o, bus_cs_o, bus_we_o;
    logic [3:0]  bus_be_o;

    logic        req0, we0, mmu0;
    logic [1:0]  size0;
    logic [31:0] paddr0, wdata0, bus_rdata0;
    logic [31:0] rdata0_o, bus_addr0_o, bus_wdata0_o;
    logic        stall0_o, fault0_o, bus_cs0_o, bus_we0_o;
    logic [3:0]  bus_be0_o;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_rd;
    vec_t vecs [10];

    always #5 clk = ~clk;

    mem_bus_ctrl #(.WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .clr(clr), .req_i(req), .we_i(we), .size_i(size),
        .paddr_i(paddr), .mmu_error_i(mmu), .wdata_i(wdata),
        .rdata_o(rdata_o), .stall_o(stall_o), .fault_o(fault_o),
        .bus_cs_o(bus_cs_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata)
    );

    mem_bus_ctrl #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .clr(clr), .req_i(req0), .we_i(we0), .size_i(size0),
        .paddr_i(paddr0), .mmu_error_i(mmu0), .wdata_i(wdata0),
        .rdata_o(rdata0_o), .stall_o(stall0_o), .fault_o(fault0_o),
        .bus_cs_o(bus_cs0_o), .bus_we_o(bus_we0_o), .bus_addr_o(bus_addr0_o),
        .bus_be_o(bus_be0_o), .bus_wdata_o(bus_wdata0_o), .bus_rdata_i(bus_rdata0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs 1 time unit after the edge, sample 4 units after it.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        next_cycle();
        req = 1'b1; we = v.we; size = v.size; paddr = v.paddr;
        mmu = v.mmu; wdata = v.wdata; bus_rdata = v.rdata;
        #3;
        chk($sformatf("v%0d fault", idx), {31'd0, fault_o}, {31'd0, v.exp_fault});
        chk($sformatf("v%0d stall_req", idx), {31'd0, stall_o}, {31'd0, ~v.exp_fault});
        next_cycle();
        // Scramble pipeline inputs: the access must already be latched.
        req = 1'b0; we = ~v.we; size = 2'b00; paddr = 32'hFFFF_FFFF;
        mmu = 1'b0; wdata = 32'h0;
        #3;
        if (v.exp_fault) begin
            chk($sformatf("v%0d cs_fault", idx), {31'd0, bus_cs_o}, 32'd0);
            chk($sformatf("v%0d stall_fault", idx), {31'd0, stall_o}, 32'd0);
            chk($sformatf("v%0d rdata_fault", idx), rdata_o, exp_rd);
        end else begin
            for (int k = 0; k <= WAIT; k++) begin
                if (k > 0) begin
                    @(posedge clk);
                    #4;
                end
                chk($sformatf("v%0d cs[%0d]", idx, k), {31'd0, bus_cs_o}, 32'd1);
                chk($sformatf("v%0d stall[%0d]", idx, k), {31'd0, stall_o}, 32'd1);
                chk($sformatf("v%0d we[%0d]", idx, k), {31'd0, bus_we_o}, {31'd0, v.we});
                chk($sformatf("v%0d be[%0d]", idx, k), {28'd0, bus_be_o}, {28'd0, v.exp_be});
                chk($sformatf("v%0d addr[%0d]", idx, k), bus_addr_o, v.exp_addr);
                chk($sformatf("v%0d wdata[%0d]", idx, k), bus_wdata_o, v.exp_wdata);
            end
            @(posedge clk);
            #4;
            if (!v.we) exp_rd = v.exp_rdata;
            chk($sformatf("v%0d done_cs", idx), {31'd0, bus_cs_o}, 32'd0);
            chk($sformatf("v%0d done_stall", idx), {31'd0, stall_o}, 32'd0);
            chk($sformatf("v%0d done_be", idx), {28'd0, bus_be_o}, 32'd0);
            chk($sformatf("v%0d done_rdata", idx), rdata_o, exp_rd);
            chk($sformatf("v%0d done_addr", idx), bus_addr_o, v.exp_addr);
        end
    endtask

    initial begin
        //          we    size   paddr         wdata         bus rdata     mmu   flt   be       addr          wdata out     rdata
        vecs[0] = '{1'b0, 2'b10, 32'h0000_1004, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'b1111, 32'h0000_1004, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 2'b00, 32'h0000_2003, 32'h0000_00A5, 32'h0BAD_0BAD, 1'b0, 1'b0, 4'b1000, 32'h0000_2000, 32'hA5A5_A5A5, 32'h0};
        vecs[2] = '{1'b0, 2'b10, 32'h0000_2100, 32'h0,         32'h1111_1111, 1'b1, 1'b1, 4'b0000, 32'h0,         32'h0,         32'h0};
`ifdef MEM_ALIGN_CHECK_EN
        vecs[3] = '{1'b0, 2'b01, 32'h0000_3001, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0,         32'h0};
        vecs[9] = '{1'b0, 2'b10, 32'h0000_9002, 32'h0,         32'h7654_3210, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0,         32'h0};
`else
        vecs[3] = '{1'b0, 2'b01, 32'h0000_3001, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 4'b0011, 32'h0000_3000, 32'h0,         32'h0000_BEEF};
        vecs[9] = '{1'b0, 2'b10, 32'h0000_9002, 32'h0,         32'h7654_3210, 1'b0, 1'b0, 4'b1111, 32'h0000_9000, 32'h0,         32'h7654_3210};
`endif
        vecs[4] = '{1'b0, 2'b00, 32'h0000_4002, 32'h0,         32'h1122_3344, 1'b0, 1'b0, 4'b0100, 32'h0000_4000, 32'h0,         32'h0000_0022};
        vecs[5] = '{1'b0, 2'b01, 32'h0000_5002, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0, 4'b1100, 32'h0000_5000, 32'h0,         32'h0000_CAFE};
        vecs[6] = '{1'b1, 2'b01, 32'h0000_6000, 32'hFFFF_1234, 32'h0,         1'b0, 1'b0, 4'b0011, 32'h0000_6000, 32'h1234_1234, 32'h0};
        vecs[7] = '{1'b1, 2'b11, 32'h0000_7008, 32'h89AB_CDEF, 32'h0,         1'b0, 1'b0, 4'b1111, 32'h0000_7008, 32'h89AB_CDEF, 32'h0};
        vecs[8] = '{1'b0, 2'b00, 32'h0000_8001, 32'h0,         32'hA1B2_C3D4, 1'b0, 1'b0, 4'b0010, 32'h0000_8000, 32'h0,         32'h0000_00C3};

        clr = 1'b1; req = 1'b0; we = 1'b0; mmu = 1'b0; size = 2'b00;
        paddr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0;
        req0 = 1'b0; we0 = 1'b0; mmu0 = 1'b0; size0 = 2'b00;
        paddr0 = 32'h0; wdata0 = 32'h0; bus_rdata0 = 32'h0;
        exp_rd = 32'h0;

        // Reset state.
        next_cycle();
        next_cycle();
        #3;
        chk("rst stall", {31'd0, stall_o}, 32'd0);
        chk("rst cs", {31'd0, bus_cs_o}, 32'd0);
        chk("rst we", {31'd0, bus_we_o}, 32'd0);
        chk("rst be", {28'd0, bus_be_o}, 32'd0);
        chk("rst addr", bus_addr_o, 32'h0);
        chk("rst wdata", bus_wdata_o, 32'h0);
        chk("rst rdata", rdata_o, 32'h0);
        next_cycle();
        clr = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // clr in the second ACCESS cycle aborts the transfer.
        next_cycle();
        req = 1'b1; we = 1'b0; size = 2'b10; paddr = 32'h0000_A000;
        mmu = 1'b0; bus_rdata = 32'h5555_AAAA;
        next_cycle();
        req = 1'b0;
        #3;
        chk("abort cs_acc1", {31'd0, bus_cs_o}, 32'd1);
        next_cycle();
        clr = 1'b1;
        next_cycle();
        clr = 1'b0;
        #3;
        exp_rd = 32'h0;
        chk("abort cs", {31'd0, bus_cs_o}, 32'd0);
        chk("abort stall", {31'd0, stall_o}, 32'd0);
        chk("abort rdata", rdata_o, 32'h0);
        run_vec(10, vecs[0]);

        // WAIT_CYCLES=0 with req held high across completion.
        next_cycle();
        req0 = 1'b1; we0 = 1'b0; size0 = 2'b10; paddr0 = 32'h0000_0100;
        bus_rdata0 = 32'h55AA_55AA;
        #3;
        chk("w0 c0 stall", {31'd0, stall0_o}, 32'd1);
        chk("w0 c0 cs", {31'd0, bus_cs0_o}, 32'd0);
        next_cycle();
        #3;
        chk("w0 c1 cs", {31'd0, bus_cs0_o}, 32'd1);
        chk("w0 c1 stall", {31'd0, stall0_o}, 32'd1);
        next_cycle();
        #3;
        chk("w0 c2 done cs", {31'd0, bus_cs0_o}, 32'd0);
        chk("w0 c2 done stall", {31'd0, stall0_o}, 32'd0);
        chk("w0 c2 rdata", rdata0_o, 32'h55AA_55AA);
        next_cycle();
        #3;
        chk("w0 c3 idle cs", {31'd0, bus_cs0_o}, 32'd0);
        chk("w0 c3 accept stall", {31'd0, stall0_o}, 32'd1);
        next_cycle();
        #3;
        chk("w0 c4 cs", {31'd0, bus_cs0_o}, 32'd1);
        req0 = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
